eth_pcs_tx_gearbox_gen: RTL and testbench

- Parametrised 64b/66b TX gearbox for the 10GBASE-R PCS.
- Takes a 2-bit sync header plus 64 scrambled bits per block, delivered in TRANS_PER_BLK pieces, and emits a constant-rate W_DATA-bit PMA word every cycle.
- Sits between the scrambler and the PMA serializer.
- Unlike the fixed-width predecessor, it supports W_DATA of 16, 32 or 64, has a valid handshake, and substitutes an invalid block on upstream underflow.

---
 rtl/eth_pcs_tx_gearbox_gen.sv | 126 ++++++++++++
 tb/tb_eth_pcs_tx_gearbox_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pcs_tx_gearbox_gen.sv
// 64b/66b TX gearbox for 10GBASE-R: packs a 2-bit sync header plus scrambled pieces into a constant-rate PMA word.
// Defining ETH_PCS_TX_GB_STATS_EN adds a saturating underflow counter with a clear input.
`timescale 1ns/1ps
module eth_pcs_tx_gearbox_gen #(
    parameter int W_DATA        = 32,
    parameter int W_SYNC        = 2,
    parameter int TRANS_PER_BLK = 64 / W_DATA,
    parameter int W_TRANS       = (TRANS_PER_BLK > 1) ? $clog2(TRANS_PER_BLK) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_valid,
    input  logic [W_SYNC-1:0]  i_sync_data,
    input  logic [W_DATA-1:0]  i_scr_data,
`ifdef ETH_PCS_TX_GB_STATS_EN
    input  logic               i_stats_clr,
    output logic [15:0]        o_underflow_cnt,
`endif
    output logic               o_req,
    output logic [W_TRANS-1:0] o_trans_cnt,
    output logic [W_DATA-1:0]  o_pma_data,
    output logic               o_underflow
);

    localparam int         W_BUF     = 2 * W_DATA;
    localparam int         BLK_SHIFT = (TRANS_PER_BLK > 1) ? $clog2(TRANS_PER_BLK) : 0;
    localparam logic [5:0] LAST_CNT  = 6'd32;

    if (W_DATA != 16 && W_DATA != 32 && W_DATA != 64) begin : g_bad_width
        $error("eth_pcs_tx_gearbox_gen: W_DATA must be 16, 32 or 64");
    end
    if (W_SYNC != 2) begin : g_bad_sync
        $error("eth_pcs_tx_gearbox_gen: W_SYNC must be 2");
    end

    logic [5:0]         cnt_q, cnt_d;
    logic [W_DATA-1:0]  left_q, left_d;
    logic [W_DATA-1:0]  pma_q, pma_d;
    logic               corrupt_q, corrupt_d;

    logic [W_TRANS-1:0] trans;
    logic [5:0]         blk;
    logic               first;
    logic [6:0]         fill;
    logic [W_BUF-1:0]   piece;
    logic [W_BUF-1:0]   mix;

    assign o_req       = i_reset_n & (cnt_q < LAST_CNT);
    assign o_trans_cnt = trans;
    assign o_pma_data  = pma_q;
    assign o_underflow = o_req & ~i_valid;

    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned and infer a latch.
        trans     = '0;
        piece     = '0;
        pma_d     = '0;
        if (TRANS_PER_BLK > 1) begin
            trans = cnt_q[W_TRANS-1:0];
        end
        first = (trans == '0);
        blk   = cnt_q >> BLK_SHIFT;
        // Leftover bits before this piece: 2 per completed block, plus the header of the current block.
        fill  = {blk, 1'b0} + (first ? 7'd0 : 7'd2);

        if (o_req) begin
            if (first) begin
                if (i_valid) begin
                    piece = {{(W_BUF-W_DATA-W_SYNC){1'b0}}, i_scr_data, i_sync_data};
                end
            end else if (i_valid && !corrupt_q) begin
                piece = {{(W_BUF-W_DATA){1'b0}}, i_scr_data};
            end
        end

        // Bit 0 of mix is the earliest bit on the wire; the PMA sends its MSB first.
        mix = {{(W_BUF-W_DATA){1'b0}}, left_q} | (piece << fill);
        for (int i = 0; i < W_DATA; i++) begin
            pma_d[W_DATA-1-i] = mix[i];
        end
        left_d = mix[W_BUF-1:W_DATA];

        cnt_d     = (cnt_q == LAST_CNT) ? 6'd0 : cnt_q + 6'd1;
        // A mid-block underflow keeps zeroing the rest of that block; its header is already gone.
        corrupt_d = o_req && !first && (corrupt_q || !i_valid);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!i_reset_n) begin
            cnt_q     <= '0;
            left_q    <= '0;
            pma_q     <= '0;
            corrupt_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            pma_q     <= pma_d;
            corrupt_q <= corrupt_d;
        end
    end

`ifdef ETH_PCS_TX_GB_STATS_EN
    logic [15:0] uf_cnt_q, uf_cnt_d;

    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (i_stats_clr) begin
            uf_cnt_d = '0;
        end else if (o_underflow && uf_cnt_q != 16'hFFFF) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            uf_cnt_q <= '0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign o_underflow_cnt = uf_cnt_q;
`endif

endmodule

// File: tb/tb_eth_pcs_tx_gearbox_gen.sv
// Directed bench for eth_pcs_tx_gearbox_gen: W_DATA 32/16/64 instances share one clock and reset.
`timescale 1ns/1ps
module tb_eth_pcs_tx_gearbox_gen;

    typedef struct {
        int   step;
        logic valid;
        logic exp_req;
        int   exp_trans;
        logic exp_uf;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        valid32, valid16, valid64;
    logic [1:0]  sync32, sync16, sync64;
    logic [31:0] scr32;
    logic [15:0] scr16;
    logic [63:0] scr64;
    logic        req32, req16, req64;
    logic [0:0]  trans32, trans64;
    logic [1:0]  trans16;
    logic [31:0] pma32;
    logic [15:0] pma16;
    logic [63:0] pma64;
    logic        uf32, uf16, uf64;
`ifdef ETH_PCS_TX_GB_STATS_EN
    logic        stats_clr;
    logic        stats_clr_off;
    logic [15:0] ucnt32, ucnt16, ucnt64;
`endif

    int   n_tests;
    int   n_fail;
    int   mc;
    int   wd [3];
    logic [63:0] cur_data [3];
    logic [1:0]  cur_sync [3];
    int   blkno [3];
    bit   corrupt [3];
    bit   eq [3][$];
    int   nword [3];
    vec_t tbl [12];

    eth_pcs_tx_gearbox_gen #(.W_DATA(32)) dut32 (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid32), .i_sync_data(sync32), .i_scr_data(scr32),
`ifdef ETH_PCS_TX_GB_STATS_EN
        .i_stats_clr(stats_clr), .o_underflow_cnt(ucnt32),
`endif
        .o_req(req32), .o_trans_cnt(trans32), .o_pma_data(pma32), .o_underflow(uf32));

    eth_pcs_tx_gearbox_gen #(.W_DATA(16)) dut16 (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid16), .i_sync_data(sync16), .i_scr_data(scr16),
`ifdef ETH_PCS_TX_GB_STATS_EN
        .i_stats_clr(stats_clr_off), .o_underflow_cnt(ucnt16),
`endif
        .o_req(req16), .o_trans_cnt(trans16), .o_pma_data(pma16), .o_underflow(uf16));

    eth_pcs_tx_gearbox_gen #(.W_DATA(64)) dut64 (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid64), .i_sync_data(sync64), .i_scr_data(scr64),
`ifdef ETH_PCS_TX_GB_STATS_EN
        .i_stats_clr(stats_clr_off), .o_underflow_cnt(ucnt64),
`endif
        .o_req(req64), .o_trans_cnt(trans64), .o_pma_data(pma64), .o_underflow(uf64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mc = 0;
        for (int k = 0; k < 3; k++) begin
            eq[k].delete();
            nword[k]   = 0;
            blkno[k]   = 0;
            corrupt[k] = 1'b0;
        end
    endtask

    // One clock: drive all three instances from the bench model, check combinational outputs,
    // then compare each registered PMA word against the expected wire-order stream.
    task automatic step(input int s, input logic v32, input logic exp_req, input int exp_trans,
                        input logic exp_uf);
        logic [63:0] piece;
        logic [63:0] expw;
        logic [63:0] act;
        logic [1:0]  sy;
        logic        v;
        int          w, tpb, t;
        for (int k = 0; k < 3; k++) begin
            w     = wd[k];
            tpb   = 64 / w;
            t     = mc % tpb;
            v     = (k == 0) ? v32 : 1'b1;
            piece = 64'hFFFF_FFFF_FFFF_FFFF;
            sy    = 2'b11;
            if (mc < 32) begin
                if (t == 0) begin
                    cur_data[k] = (k == 0) ? 64'h0123_4567_89AB_CDEF
                                           : 64'hF0E1_D2C3_0000_0000 + 64'(blkno[k]);
                    cur_sync[k] = (k == 0 || blkno[k] % 2 == 0) ? 2'b01 : 2'b10;
                    corrupt[k]  = 1'b0;
                    eq[k].push_back(v ? cur_sync[k][0] : 1'b0);
                    eq[k].push_back(v ? cur_sync[k][1] : 1'b0);
                end
                piece = cur_data[k] >> (t * w);
                sy    = cur_sync[k];
                if (!v && t != 0) corrupt[k] = 1'b1;
                for (int i = 0; i < w; i++) begin
                    eq[k].push_back((v && !corrupt[k]) ? piece[i] : 1'b0);
                end
                if (t == tpb - 1) blkno[k]++;
            end
            case (k)
                0: begin valid32 = v32; sync32 = sy; scr32 = piece[31:0]; end
                1: begin valid16 = 1'b1; sync16 = sy; scr16 = piece[15:0]; end
                default: begin valid64 = 1'b1; sync64 = sy; scr64 = piece; end
            endcase
        end
        #1;
        check($sformatf("req32@%0d", s), 64'(req32), 64'(exp_req));
        check($sformatf("trans32@%0d", s), 64'(trans32), 64'(exp_trans));
        check($sformatf("uf32@%0d", s), 64'(uf32), 64'(exp_uf));
        check($sformatf("req16@%0d", s), 64'(req16), 64'(mc < 32));
        check($sformatf("trans16@%0d", s), 64'(trans16), 64'(mc % 4));
        check($sformatf("uf16@%0d", s), 64'(uf16), 64'd0);
        check($sformatf("req64@%0d", s), 64'(req64), 64'(mc < 32));
        check($sformatf("trans64@%0d", s), 64'(trans64), 64'd0);
        check($sformatf("uf64@%0d", s), 64'(uf64), 64'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            w    = wd[k];
            expw = '0;
            act  = (k == 0) ? 64'(pma32) : (k == 1) ? 64'(pma16) : pma64;
            if (eq[k].size() < (nword[k] + 1) * w) begin
                check($sformatf("stream_len%0d@%0d", w, s), 64'(eq[k].size()), 64'((nword[k] + 1) * w));
            end else begin
                for (int i = 0; i < w; i++) begin
                    expw[w-1-i] = eq[k][nword[k]*w + i];
                end
                check($sformatf("pma%0d@%0d", w, s), act, expw);
            end
            nword[k]++;
        end
        mc = (mc == 32) ? 0 : mc + 1;
        @(negedge clk);
    endtask

    task automatic step_default(input int s);
        step(s, 1'b1, 1'((s % 33) != 32), (s % 33) % 2, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req32"}, 64'(req32), 64'd0);
        check({tag, "_trans32"}, 64'(trans32), 64'd0);
        check({tag, "_uf32"}, 64'(uf32), 64'd0);
        check({tag, "_pma32"}, 64'(pma32), 64'd0);
        check({tag, "_pma16"}, 64'(pma16), 64'd0);
        check({tag, "_pma64"}, pma64, 64'd0);
        check({tag, "_req64"}, 64'(req64), 64'd0);
    endtask

    initial begin
        int  s;
        bit  found;
        vec_t row;
        n_tests = 0;
        n_fail  = 0;
        wd[0] = 32; wd[1] = 16; wd[2] = 64;
        tbl[0]  = '{0,   1'b1, 1'b1, 0, 1'b0};
        tbl[1]  = '{31,  1'b1, 1'b1, 1, 1'b0};
        tbl[2]  = '{32,  1'b1, 1'b0, 0, 1'b0};
        tbl[3]  = '{33,  1'b1, 1'b1, 0, 1'b0};
        tbl[4]  = '{39,  1'b0, 1'b1, 0, 1'b1};
        tbl[5]  = '{40,  1'b1, 1'b1, 1, 1'b0};
        tbl[6]  = '{65,  1'b1, 1'b0, 0, 1'b0};
        tbl[7]  = '{73,  1'b0, 1'b1, 1, 1'b1};
        tbl[8]  = '{74,  1'b1, 1'b1, 0, 1'b0};
        tbl[9]  = '{98,  1'b1, 1'b0, 0, 1'b0};
        tbl[10] = '{131, 1'b0, 1'b0, 0, 1'b0};
        tbl[11] = '{132, 1'b1, 1'b1, 0, 1'b0};

        rst_n   = 1'b0;
        valid32 = 1'b1; valid16 = 1'b1; valid64 = 1'b1;
        sync32  = 2'b01; sync16 = 2'b01; sync64 = 2'b01;
        scr32   = '1; scr16 = '1; scr64 = '1;
`ifdef ETH_PCS_TX_GB_STATS_EN
        stats_clr     = 1'b0;
        stats_clr_off = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Four periods with underflows on block 3 piece 0 and piece 1 in different periods.
        rst_n = 1'b1;
        for (s = 0; s < 140; s++) begin
            found = 1'b0;
            row   = '{0, 1'b1, 1'b1, 0, 1'b0};
            for (int r = 0; r < 12; r++) begin
                if (tbl[r].step == s) begin
                    found = 1'b1;
                    row   = tbl[r];
                end
            end
            if (found) step(s, row.valid, row.exp_req, row.exp_trans, row.exp_uf);
            else       step_default(s);
        end

        // Reset mid-period at q_cnt=17 for three cycles.
        for (int guard = 0; guard < 40 && mc != 17; guard++) begin
            step_default(s);
            s++;
        end
        check("reach_cnt17", 64'(mc), 64'd17);
        rst_n   = 1'b0;
        valid32 = 1'b0;
        #1;
        check_all_zero("midrst_async");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all_zero("midrst");
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (s = 0; s < 70; s++) begin
            step_default(s);
            if (s == 0) check("post_rst_sync", 64'(pma32[31:30]), 64'(2'b10));
        end

`ifdef ETH_PCS_TX_GB_STATS_EN
        begin
            int uf_total;
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            check("stats_reset", 64'(ucnt32), 64'd0);
            rst_n    = 1'b1;
            mc       = 0;
            uf_total = 0;
            valid32  = 1'b0;
            while (uf_total < 65540) begin
                @(posedge clk);
                #1;
                if (mc < 32) uf_total++;
                mc = (mc == 32) ? 0 : mc + 1;
                if (uf_total == 10 && mc == 10) check("stats_cnt10", 64'(ucnt32), 64'd10);
                @(negedge clk);
            end
            check("stats_saturated", 64'(ucnt32), 64'hFFFF);
            check("stats_other_inst", 64'(ucnt16), 64'd0);
            if (mc == 32) begin
                @(posedge clk);
                mc = 0;
                @(negedge clk);
            end
            stats_clr = 1'b1;
            #1;
            check("stats_clr_uf", 64'(uf32), 64'd1);
            @(posedge clk);
            #1;
            mc = (mc == 32) ? 0 : mc + 1;
            check("stats_clr_wins", 64'(ucnt32), 64'd0);
            @(negedge clk);
            stats_clr = 1'b0;
            if (mc == 32) begin
                @(posedge clk);
                mc = 0;
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            check("stats_after_clr", 64'(ucnt32), 64'd1);
            @(negedge clk);
            valid32 = 1'b1;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
